// File: rtl/kfmmc_multi_block_sequencer.sv
// kfmmc_multi_block_sequencer: multi-block read/write engine between a host byte stream and the KFMMC drive bus.
module kfmmc_multi_block_sequencer #(
    parameter int         BLOCK_BYTES = 512,
    parameter int         COUNT_WIDTH = 8,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] READ_CMD    = 8'h80,
    parameter logic [7:0] WRITE_CMD   = 8'h81
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   direction,
    input  logic [31:0]            start_lba,
    input  logic [COUNT_WIDTH-1:0] block_count,
    input  logic                   abort,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code,
    output logic [COUNT_WIDTH-1:0] blocks_done,
    output logic [31:0]            current_lba,
    output logic [7:0]             drv_data_bus,
    output logic                   drv_write_block_address_1,
    output logic                   drv_write_block_address_2,
    output logic                   drv_write_block_address_3,
    output logic                   drv_write_block_address_4,
    output logic                   drv_write_access_command,
    output logic                   drv_write_data,
    output logic                   drv_read_data,
    input  logic [7:0]             drv_read_data_byte,
    input  logic                   drv_busy,
    input  logic                   drv_read_interface_error,
    input  logic                   drv_read_crc_error,
    input  logic                   drv_write_interface_error,
    input  logic                   drv_block_read_interrupt,
    input  logic                   drv_read_completion_interrupt,
    input  logic                   drv_request_write_data_interrupt,
    input  logic                   drv_write_completion_interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BLOCK_BYTES) + 2;
    localparam int HW = COUNT_WIDTH + $clog2(BLOCK_BYTES) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_CMD, S_WAIT_BUSY, S_XFER, S_GAP, S_NEXT, S_ABORTING, S_FLUSH, S_DONE
    } state_t;

    state_t                 state;
    logic                   dir;
    logic                   hold;
    logic [1:0]             addr_idx;
    logic [3:0]             addr_stb;
    logic [COUNT_WIDTH-1:0] count;
    logic [BW-1:0]          byte_cnt;
    logic [HW-1:0]          host_left;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wp, rp;
    logic [AW:0]            fcnt;
    logic                   empty, full, cmpl, fail, xfer_ok;
    logic                   drv_push, drv_pop, host_push, host_pop, push, pop, fifo_clr;

    assign {drv_write_block_address_4, drv_write_block_address_3,
            drv_write_block_address_2, drv_write_block_address_1} = addr_stb;

    assign empty     = fcnt == '0;
    assign full      = fcnt == (AW+1)'(FIFO_DEPTH);
    assign rd_data   = empty ? 8'h00 : mem[rp];
    assign rd_valid  = !empty && !dir;
    assign wr_ready  = busy && dir && !full && state != S_ABORTING && host_left != '0;
    assign cmpl      = dir ? drv_write_completion_interrupt : drv_read_completion_interrupt;
    assign fail      = busy && !error && (abort || drv_read_interface_error || drv_read_crc_error ||
                                          drv_write_interface_error);
    assign xfer_ok   = state == S_XFER && !fail && !cmpl;
    assign drv_push  = xfer_ok && !dir && drv_block_read_interrupt && !full;
    assign drv_pop   = xfer_ok && dir && drv_request_write_data_interrupt && !empty;
    assign host_push = wr_valid && wr_ready;
    assign host_pop  = rd_valid && rd_ready;
    assign push      = drv_push || host_push;
    assign pop       = drv_pop || host_pop;
    assign fifo_clr  = (state == S_IDLE && start) || (state == S_ABORTING && !drv_busy);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else if (fifo_clr) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            wp   <= wp + AW'(push);
            rp   <= rp + AW'(pop);
            fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !fifo_clr) mem[wp] <= host_push ? wr_data : drv_read_data_byte;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                    <= S_IDLE;
            dir                      <= 1'b0;
            hold                     <= 1'b0;
            addr_idx                 <= '0;
            addr_stb                 <= '0;
            count                    <= '0;
            byte_cnt                 <= '0;
            host_left                <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            error                    <= 1'b0;
            error_code               <= 2'b00;
            blocks_done              <= '0;
            current_lba              <= '0;
            drv_data_bus             <= '0;
            drv_write_access_command <= 1'b0;
            drv_write_data           <= 1'b0;
            drv_read_data            <= 1'b0;
        end else begin
            addr_stb                 <= '0;
            drv_write_access_command <= 1'b0;
            drv_write_data           <= 1'b0;
            drv_read_data            <= 1'b0;
            done                     <= 1'b0;
            if (host_push) host_left <= host_left - 1'b1;
            // first error wins; the drive is then run out of its current op
            if (fail) begin
                error      <= 1'b1;
                error_code <= (drv_read_interface_error || drv_read_crc_error) ? 2'b01 :
                              drv_write_interface_error ? 2'b10 : 2'b11;
                hold       <= 1'b0;
                state      <= S_ABORTING;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        dir         <= direction;
                        count       <= block_count;
                        current_lba <= start_lba;
                        blocks_done <= '0;
                        error       <= 1'b0;
                        error_code  <= 2'b00;
                        addr_idx    <= '0;
                        host_left   <= HW'(block_count) * HW'(BLOCK_BYTES);
                        done        <= block_count == '0;
                        busy        <= block_count != '0;
                        state       <= block_count == '0 ? S_DONE : S_ADDR;
                    end
                    S_ADDR: begin
                        addr_stb     <= 4'b0001 << addr_idx;
                        drv_data_bus <= 8'(current_lba >> {addr_idx, 3'b000});
                        addr_idx     <= addr_idx + 1'b1;
                        if (addr_idx == 2'd3) state <= S_CMD;
                    end
                    S_CMD: begin
                        drv_write_access_command <= 1'b1;
                        drv_data_bus             <= dir ? WRITE_CMD : READ_CMD;
                        byte_cnt                 <= '0;
                        state                    <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: if (drv_busy) state <= S_XFER;
                    S_XFER: begin
                        if (cmpl) begin
                            if (byte_cnt == BW'(BLOCK_BYTES)) state <= S_NEXT;
                            else begin
                                error      <= 1'b1;
                                error_code <= 2'b11;
                                state      <= S_FLUSH;
                            end
                        end else if (drv_push) begin
                            drv_read_data <= 1'b1;
                            byte_cnt      <= byte_cnt + 1'b1;
                            state         <= S_GAP;
                        end else if (drv_pop) begin
                            drv_data_bus   <= rd_data;
                            drv_write_data <= 1'b1;
                            byte_cnt       <= byte_cnt + 1'b1;
                            state          <= S_GAP;
                        end
                    end
                    S_GAP: state <= S_XFER;
                    S_NEXT: begin
                        blocks_done <= blocks_done + 1'b1;
                        current_lba <= current_lba + 1'b1;
                        state       <= (blocks_done + 1'b1 == count) ? S_FLUSH : S_ADDR;
                    end
                    // hold spaces strobes so the drive can drop its interrupt
                    S_ABORTING: begin
                        if (!drv_busy) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if (hold) hold <= 1'b0;
                        else if (!dir && drv_block_read_interrupt) begin
                            drv_read_data <= 1'b1;
                            hold          <= 1'b1;
                        end else if (dir && drv_request_write_data_interrupt) begin
                            drv_data_bus   <= 8'h00;
                            drv_write_data <= 1'b1;
                            hold           <= 1'b1;
                        end
                    end
                    S_FLUSH: if (dir || empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
